// File: rtl/cla_nibble_seq.sv
// ----------------------------------------------------------------------------
// cla_nibble_seq
//   Nibble-serial sequencer wrapped around an external 4-bit carry-lookahead
//   adder. A wide operand pair is latched on start. Each cycle in RUN, one
//   nibble pair and the rippled carry go out to the CLA, and its 4-bit sum and
//   carry-out come back. The full-width result is registered on the last
//   nibble, and done pulses for one cycle.
//
//   Optional feature macro: CLA_SEQ_OVF_EN adds the registered signed-overflow
//   output ovf. When the macro is undefined, ovf and its logic are absent.
//
// Parameters
//   NIBBLES   operand width in nibbles (2..8); W = 4*NIBBLES
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request, sampled only in IDLE or DONE
//   a_in      in   W   operand A (sampled with start)
//   b_in      in   W   operand B (sampled with start)
//   cin       in   carry-in (sampled with start)
//   busy      out  high while in RUN
//   done      out  one-cycle completion pulse
//   sum_out   out  W   registered result, held until next completion
//   cout      out  registered final carry-out
//   cla_a     out  4   current nibble of A to the CLA (0 outside RUN)
//   cla_b     out  4   current nibble of B to the CLA (0 outside RUN)
//   cla_cin   out  current carry to the CLA (0 outside RUN)
//   cla_sum   in   4   CLA sum (combinational from cla_a/cla_b/cla_cin)
//   cla_cout  in   CLA carry-out
//   ovf       out  signed overflow (only with CLA_SEQ_OVF_EN)
// ----------------------------------------------------------------------------
module cla_nibble_seq #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum_out,
    output logic         cout,
    output logic [3:0]   cla_a,
    output logic [3:0]   cla_b,
    output logic         cla_cin,
    input  logic [3:0]   cla_sum,
    input  logic         cla_cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    // Only the lower nibbles are stored here. The top nibble goes straight
    // from cla_sum into sum_out on the completion edge.
    logic [W-5:0]   r_work;
    logic           r_carry;
    logic [IW-1:0]  r_idx;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_sum;
    logic           r_cout;
`ifdef CLA_SEQ_OVF_EN
    logic           r_ovf;
`endif

    logic           w_run;
    logic [IW+1:0]  w_base;

    assign w_run  = (r_state == S_RUN);
    assign w_base = {r_idx, 2'b00};

    // CLA drive is combinational from the registered state, so the whole
    // CLA round trip fits inside one clock period.
    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (w_run) begin
            cla_a   = r_a[w_base +: 4];
            cla_b   = r_b[w_base +: 4];
            cla_cin = r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_carry <= cla_cout;
                    if (r_idx == LAST) begin
                        r_sum   <= {cla_sum, r_work};
                        r_cout  <= cla_cout;
`ifdef CLA_SEQ_OVF_EN
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (cla_sum[3] != r_a[W-1]);
`endif
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_work[w_base +: 4] <= cla_sum;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum;
    assign cout    = r_cout;
`ifdef CLA_SEQ_OVF_EN
    assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_cla_nibble_seq.sv
// ----------------------------------------------------------------------------
// tb_cla_nibble_seq
//   Self-checking bench for cla_nibble_seq with NIBBLES=4. The bench models
//   the CLA as a plain 4-bit add. Expected results come from whole-word
//   arithmetic on the operands: the carry into each nibble, the final sum and
//   carry, and the signed overflow. Stimulus is directed cases followed by
//   $urandom operations. Some of the random operations start back-to-back,
//   and some assert spurious starts during RUN.
// ----------------------------------------------------------------------------
module tb_cla_nibble_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
    logic [3:0]   cla_a;
    logic [3:0]   cla_b;
    logic         cla_cin;
    logic [3:0]   cla_sum;
    logic         cla_cout;
`ifdef CLA_SEQ_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    // Behavioural 4-bit CLA
    always_comb {cla_cout, cla_sum} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

    cla_nibble_seq #(.NIBBLES(N)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout     (cout),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_sum  (cla_sum),
        .cla_cout (cla_cout)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_done = 0;
    int           n_exp_done = 0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;

    always @(negedge clk) if (done) n_done++;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        return (s > longint'(2**(W-1)) - 1) || (s < -longint'(2**(W-1)));
    endfunction

    task automatic idle_chk();
        tick();
        chk_eq("idle_busy", busy, 1'b0);
        chk_eq("idle_done", done, 1'b0);
        chk_eq("idle_sum", sum_out, held_sum);
        chk_eq("idle_cla_a", cla_a, 4'h0);
    endtask

    // Entered at #1 after an edge with the DUT in IDLE or DONE. Returns at
    // #1 after the completion edge, that is, in the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit junk);
        longint unsigned mask;
        longint unsigned full;
        logic            carry;
        full  = longint'(a) + longint'(b) + longint'(c);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        tick();  // E0
        for (int k = 0; k < N; k++) begin
            if (junk) begin
                a_in  = W'($urandom);
                b_in  = W'($urandom);
                cin   = 1'($urandom);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            mask  = (64'd1 << (4 * k)) - 64'd1;
            carry = 1'(((longint'(a) & mask) + (longint'(b) & mask) + longint'(c)) >> (4 * k));
            chk_eq("run_busy", busy, 1'b1);
            chk_eq("run_done", done, 1'b0);
            chk_eq("run_sum_held", sum_out, held_sum);
            chk_eq("run_cout_held", cout, held_cout);
            chk_eq("cla_a", cla_a, 4'((a >> (4 * k)) & 16'hF));
            chk_eq("cla_b", cla_b, 4'((b >> (4 * k)) & 16'hF));
            chk_eq("cla_cin", cla_cin, carry);
            tick();
        end
        start = 1'b0;
        n_exp_done++;
        held_sum  = W'(full);
        held_cout = 1'(full >> W);
        chk_eq("done", done, 1'b1);
        chk_eq("done_busy", busy, 1'b0);
        chk_eq("sum_out", sum_out, held_sum);
        chk_eq("cout", cout, held_cout);
        chk_eq("done_cla_a", cla_a, 4'h0);
        chk_eq("done_cla_cin", cla_cin, 1'b0);
`ifdef CLA_SEQ_OVF_EN
        chk_eq("ovf", ovf, exp_ovf(a, b, c));
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        tick();
        tick();
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_done", done, 1'b0);
        chk_eq("rst_sum", sum_out, '0);
        chk_eq("rst_cout", cout, 1'b0);
        chk_eq("rst_cla_a", cla_a, 4'h0);
        chk_eq("rst_cla_b", cla_b, 4'h0);
        chk_eq("rst_cla_cin", cla_cin, 1'b0);
`ifdef CLA_SEQ_OVF_EN
        chk_eq("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;
        idle_chk();

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle_chk();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);  // started in the DONE cycle
        idle_chk();
        run_op(16'h0F0F, 16'h7777, 1'b1, 1'b1);  // start held during RUN
        idle_chk();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle_chk();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle_chk();
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle_chk();

        // Reset at E2 aborts the operation in flight
        a_in  = 16'hABCD;
        b_in  = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        tick();  // E0
        start = 1'b0;
        tick();  // E1
        rst = 1'b1;
        tick();  // E2
        rst = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        chk_eq("abort_busy", busy, 1'b0);
        chk_eq("abort_done", done, 1'b0);
        chk_eq("abort_sum", sum_out, '0);
        chk_eq("abort_cout", cout, 1'b0);
        chk_eq("abort_cla_a", cla_a, 4'h0);
        repeat (5) idle_chk();
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        idle_chk();

        // Random operations
        for (int i = 0; i < 30; i++) begin
            bit b2b;
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(2) == 0));
            b2b = ($urandom_range(1) == 1);
            if (!b2b) idle_chk();
        end
        idle_chk();

        chk_eq("done_count", 32'(n_done), 32'(n_exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
